// File: rtl/alarm_pkg.sv
// Shared types and default parameters for the alarm controller slice.
// ALARM_COUNT_EN (in alarm_controller) enables the alarm event counter.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SIREN    = 2'd2,
        ST_COOLDOWN = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        DET_START = 2'd0,
        DET_GOT01 = 2'd1,
        DET_GOT10 = 2'd2
    } det_state_t;

    localparam int DEF_NBITS           = 2;
    localparam int DEF_SIREN_CYCLES    = 8;
    localparam int DEF_COOLDOWN_CYCLES = 4;
    localparam int DEF_CNT_W           = 4;
    localparam int TIMER_W             = 8;

endpackage

// File: rtl/lamp_seq_detect.sv
// Lamp code sequence detector: registered one-cycle hit after sampling
// codes 01, 10, 11 on consecutive cycles; code 01 always restarts at step 1.
module lamp_seq_detect
    import alarm_pkg::*;
#(
    parameter int NBITS = DEF_NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] lampadas,
    output logic             hit
);

    localparam logic [NBITS-1:0] CODE_01 = NBITS'(1);
    localparam logic [NBITS-1:0] CODE_10 = NBITS'(2);
    localparam logic [NBITS-1:0] CODE_11 = NBITS'(3);

    det_state_t state, state_next;
    logic       hit_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DET_START;
            hit   <= 1'b0;
        end else begin
            state <= state_next;
            hit   <= hit_next;
        end
    end

    // NOTE: defaults first so no path through the block leaves an output unassigned (no latch).
    always_comb begin
        state_next = DET_START;
        hit_next   = 1'b0;
        if (lampadas == CODE_01) begin
            state_next = DET_GOT01;
        end else begin
            case (state)
                DET_GOT01: if (lampadas == CODE_10) state_next = DET_GOT10;
                DET_GOT10: if (lampadas == CODE_11) hit_next = 1'b1;
                default:   state_next = DET_START;
            endcase
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: IDLE/ARMED/SIREN/COOLDOWN with one shared 8-bit timer.
// Define ALARM_COUNT_EN to build the saturating alarm_count register.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int NBITS           = DEF_NBITS,
    parameter int SIREN_CYCLES    = DEF_SIREN_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             disarm,
    input  logic             ack,
    input  logic [NBITS-1:0] lampadas,
    output logic             armed,
    output logic             siren,
    output logic             alarm_pending,
    output logic [CNT_W-1:0] alarm_count
);

    localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOL_LOAD  = TIMER_W'(COOLDOWN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    ctrl_state_t        state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               hit;
    logic               det_reset;
    logic               siren_entry;
    logic               pending_next;

    // The detector only searches while ARMED; elsewhere it is held at its start state.
    assign det_reset = reset || (state != ST_ARMED);

    lamp_seq_detect #(
        .NBITS(NBITS)
    ) u_detect (
        .clk      (clk),
        .reset    (det_reset),
        .lampadas (lampadas),
        .hit      (hit)
    );

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        siren_entry = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (hit) begin
                    state_next  = ST_SIREN;
                    timer_next  = SIREN_LOAD;
                    siren_entry = 1'b1;
                end else if (disarm) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SIREN: begin
                if (ack || timer == '0) begin
                    state_next = ST_COOLDOWN;
                    timer_next = COOL_LOAD;
                end else begin
                    timer_next = timer - TIMER_ONE;
                end
            end
            ST_COOLDOWN: begin
                if (disarm) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end else if (timer == '0) begin
                    state_next = ST_ARMED;
                end else begin
                    timer_next = timer - TIMER_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase
        // A new alarm outranks an acknowledge arriving in the same cycle.
        pending_next = siren_entry ? 1'b1 : (ack ? 1'b0 : alarm_pending);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            timer         <= '0;
            armed         <= 1'b0;
            siren         <= 1'b0;
            alarm_pending <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            armed         <= (state_next != ST_IDLE);
            siren         <= (state_next == ST_SIREN);
            alarm_pending <= pending_next;
        end
    end

`ifdef ALARM_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (siren_entry && count_q != '1) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign alarm_count = count_q;
`else
    assign alarm_count = '0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_alarm_controller;
    import alarm_pkg::*;

    localparam int NBITS   = 2;
    localparam int SIREN_N = 8;
    localparam int COOL_N  = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ALARM_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, arm, disarm, ack;
    logic [NBITS-1:0] lampadas;
    logic             armed, siren, alarm_pending;
    logic [CNT_W-1:0] alarm_count;

    always #5 clk = ~clk;

    alarm_controller #(
        .NBITS           (NBITS),
        .SIREN_CYCLES    (SIREN_N),
        .COOLDOWN_CYCLES (COOL_N),
        .CNT_W           (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .disarm        (disarm),
        .ack           (ack),
        .lampadas      (lampadas),
        .armed         (armed),
        .siren         (siren),
        .alarm_pending (alarm_pending),
        .alarm_count   (alarm_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode plus cycles left in it, and the last three lamp samples taken while armed.
    typedef enum {M_IDLE, M_ARMED, M_SIREN, M_COOLDOWN} mode_t;
    mode_t m_mode;
    int    m_left;
    int    m_win[$];
    bit    m_hit;
    bit    m_pending;
    int    m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        mode_t old_mode = m_mode;
        bit    old_hit  = m_hit;
        bit    entering = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_left = 0; m_win.delete(); m_hit = 0; m_pending = 0; m_count = 0;
            return;
        end
        if (old_mode == M_ARMED) begin
            m_win.push_back(int'(lampadas));
            if (m_win.size() > 3) void'(m_win.pop_front());
            m_hit = (m_win.size() == 3 && m_win[0] == 1 && m_win[1] == 2 && m_win[2] == 3);
        end else begin
            m_win.delete();
            m_hit = 0;
        end
        case (old_mode)
            M_IDLE:  if (arm) m_mode = M_ARMED;
            M_ARMED: begin
                if (old_hit) begin m_mode = M_SIREN; m_left = SIREN_N; entering = 1; end
                else if (disarm) m_mode = M_IDLE;
            end
            M_SIREN: begin
                if (ack || m_left == 1) begin m_mode = M_COOLDOWN; m_left = COOL_N; end
                else m_left--;
            end
            M_COOLDOWN: begin
                if (disarm) m_mode = M_IDLE;
                else if (m_left == 1) m_mode = M_ARMED;
                else m_left--;
            end
        endcase
        if (entering) m_pending = 1;
        else if (ack) m_pending = 0;
        if (entering && COUNT_EN && m_count < CNT_MAX) m_count++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("armed", armed, m_mode != M_IDLE);
        check("siren", siren, m_mode == M_SIREN);
        check("pending", alarm_pending, m_pending);
        check("count", alarm_count, m_count);
    endtask

    task automatic lamp_tick(input int l);
        arm = 0; disarm = 0; ack = 0; lampadas = NBITS'(l);
        tick();
    endtask

    task automatic detect_into_siren();
        lamp_tick(1); lamp_tick(2); lamp_tick(3); lamp_tick(0);
    endtask

    initial begin
        int siren_len;
        bit saw;
        int seq[$];

        reset = 1; arm = 0; disarm = 0; ack = 0; lampadas = '0;
        m_mode = M_IDLE; m_left = 0; m_hit = 0; m_pending = 0; m_count = 0;
        tick(); tick();
        check("rst_armed", armed, 0);
        check("rst_state", dut.state, ST_IDLE);
        reset = 0;

        // Basic detection, full siren, full cooldown
        arm = 1; tick(); arm = 0;
        check("arm_armed", armed, 1);
        lamp_tick(1); lamp_tick(2); lamp_tick(3);
        check("hit", dut.u_detect.hit, 1);
        lamp_tick(0);
        check("siren_on", siren, 1);
        check("pending_on", alarm_pending, 1);
        check("count_1", alarm_count, COUNT_EN ? 1 : 0);
        siren_len = 1;
        for (int i = 0; i < 20; i++) begin
            lamp_tick(0);
            if (siren) siren_len++;
            else break;
        end
        check("siren_len", siren_len, SIREN_N);
        check("cool_state", dut.state, ST_COOLDOWN);
        for (int i = 0; i < COOL_N; i++) lamp_tick(0);
        check("back_armed", dut.state, ST_ARMED);
        ack = 1; tick(); ack = 0;
        check("ack_clear", alarm_pending, 0);

        // Broken sequence must not fire; 01 restarts mid-search
        saw = 0;
        foreach (seq[i]) seq.delete(i);
        seq = '{1, 2, 0, 2, 3, 0, 0};
        foreach (seq[i]) begin lamp_tick(seq[i]); saw |= siren; end
        check("no_false_hit", saw, 0);
        lamp_tick(1); lamp_tick(1); lamp_tick(2); lamp_tick(3); lamp_tick(0);
        check("restart_hit", siren, 1);

        // Disarm ignored in SIREN, ack on third siren cycle
        disarm = 1; tick(); tick();
        check("disarm_ignored", siren, 1);
        disarm = 0; ack = 1; tick(); ack = 0;
        check("ack_siren_off", siren, 0);
        check("ack_pending_off", alarm_pending, 0);
        check("ack_cooldown", dut.state, ST_COOLDOWN);
        for (int i = 0; i < COOL_N; i++) lamp_tick(0);
        check("armed_again", dut.state, ST_ARMED);

        // Hit beats disarm; disarm in COOLDOWN goes IDLE
        lamp_tick(1); lamp_tick(2); lamp_tick(3);
        disarm = 1; lampadas = '0; tick(); disarm = 0;
        check("hit_wins", siren, 1);
        ack = 1; tick(); ack = 0;
        disarm = 1; tick(); disarm = 0;
        check("cool_disarm", armed, 0);
        check("cool_disarm_st", dut.state, ST_IDLE);

        // Counter saturation over five detections
        reset = 1; tick(); reset = 0;
        arm = 1; tick(); arm = 0;
        for (int k = 0; k < 5; k++) begin
            detect_into_siren();
            ack = 1; tick(); ack = 0;
            for (int i = 0; i < COOL_N; i++) lamp_tick(0);
        end
        check("count_sat", alarm_count, COUNT_EN ? CNT_MAX : 0);

        // Reset on fifth siren cycle
        detect_into_siren();
        for (int i = 0; i < 4; i++) lamp_tick(0);
        check("siren_c5", siren, 1);
        reset = 1; tick(); reset = 0;
        check("rst_siren", siren, 0);
        check("rst_pending", alarm_pending, 0);
        check("rst_count", alarm_count, 0);
        check("rst_mid_state", dut.state, ST_IDLE);
        lamp_tick(0);
        check("stay_idle", armed, 0);

        // Randomized traffic
        seq.delete();
        for (int n = 0; n < 1500; n++) begin
            reset  = ($urandom_range(0, 149) == 0);
            arm    = ($urandom_range(0, 3) == 0);
            disarm = ($urandom_range(0, 11) == 0);
            ack    = ($urandom_range(0, 9) == 0);
            if (seq.size() == 0 && $urandom_range(0, 4) == 0) seq = '{1, 2, 3};
            if (seq.size() != 0) lampadas = NBITS'(seq.pop_front());
            else lampadas = NBITS'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
